// File: rtl/clock_set_controller.sv
// clock_set_controller: button-driven time-set sequencer for DigitalClock.
// RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN, with BCD field increment,
// a one-cycle load strobe on commit and a blink enable for the edited field.
// Optional macro CLK_SET_TIMEOUT_EN: abandons an edit after TIMEOUT_SECS
// one_sec_pulse ticks with no button activity.
module clock_set_controller #(
  parameter int unsigned TIMEOUT_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec_pulse,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  output logic       clock_hold,
  output logic       load,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_ones,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_ones,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  // Reject out-of-range timeout values at elaboration time.
  if (TIMEOUT_SECS < 1 || TIMEOUT_SECS > 255) begin : g_bad_timeout
    $error("TIMEOUT_SECS must be in 1..255");
  end

  state_t     state, state_nxt;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
  logic [3:0] hour_tens_nxt, hour_ones_nxt, min_tens_nxt, min_ones_nxt;
  logic       blink_nxt;
  logic       in_edit;
  logic       timeout_hit;

  // Hours field: any bad digit or a value above 23 clears the whole field.
  function automatic logic [7:0] sanitise_hour(input logic [3:0] t, input logic [3:0] o);
    if (t > 4'd2 || o > 4'd9 || (t == 4'd2 && o > 4'd3))
      return 8'h00;
    return {t, o};
  endfunction

  // Minutes field: any bad digit or a tens digit above 5 clears the field.
  function automatic logic [7:0] sanitise_min(input logic [3:0] t, input logic [3:0] o);
    if (t > 4'd5 || o > 4'd9)
      return 8'h00;
    return {t, o};
  endfunction

  // BCD hour increment, 23 wraps to 00.
  function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3)
      return 8'h00;
    if (o == 4'd9)
      return {t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  // BCD minute increment, 59 wraps to 00 with no carry into hours.
  function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9)
      return {(t == 4'd5) ? 4'd0 : t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  assign in_edit = (state == SET_HOUR) || (state == SET_MIN);

`ifdef CLK_SET_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_SECS);

  logic [7:0] idle_cnt, idle_cnt_nxt;

  // A button in the same cycle as the terminal tick wins and clears the count.
  always_comb begin
    timeout_hit  = in_edit && one_sec_pulse && !btn_mode && !btn_inc &&
                   ((idle_cnt + 8'd1) == TIMEOUT_LIMIT);
    idle_cnt_nxt = idle_cnt;
    if (!in_edit || btn_mode || btn_inc || timeout_hit)
      idle_cnt_nxt = '0;
    else if (one_sec_pulse)
      idle_cnt_nxt = idle_cnt + 8'd1;
  end

  // Idle-second counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt_nxt;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // Next-state logic; btn_mode always takes precedence over btn_inc.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (btn_mode) state_nxt = SET_HOUR;
      SET_HOUR: if (btn_mode) state_nxt = SET_MIN;
                else if (timeout_hit) state_nxt = RUN;
      SET_MIN:  if (btn_mode) state_nxt = COMMIT;
                else if (timeout_hit) state_nxt = RUN;
      COMMIT:   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Edit-register next values: capture in RUN, increment the active field.
  always_comb begin
    {hour_tens_nxt, hour_ones_nxt} = {hour_tens, hour_ones};
    {min_tens_nxt, min_ones_nxt}   = {min_tens, min_ones};
    if (state == RUN && btn_mode) begin
      {hour_tens_nxt, hour_ones_nxt} = sanitise_hour(cur_hour_tens, cur_hour_ones);
      {min_tens_nxt, min_ones_nxt}   = sanitise_min(cur_min_tens, cur_min_ones);
    end else if (state == SET_HOUR && btn_inc && !btn_mode) begin
      {hour_tens_nxt, hour_ones_nxt} = inc_hour(hour_tens, hour_ones);
    end else if (state == SET_MIN && btn_inc && !btn_mode) begin
      {min_tens_nxt, min_ones_nxt} = inc_min(min_tens, min_ones);
    end
  end

  // Edit registers; they keep their value after commit until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hour_tens <= '0;
      hour_ones <= '0;
      min_tens  <= '0;
      min_ones  <= '0;
    end else begin
      hour_tens <= hour_tens_nxt;
      hour_ones <= hour_ones_nxt;
      min_tens  <= min_tens_nxt;
      min_ones  <= min_ones_nxt;
    end
  end

  // Blink toggles per second while editing and restarts low on every state change.
  always_comb begin
    blink_nxt = 1'b0;
    if (state_nxt == state && in_edit)
      blink_nxt = one_sec_pulse ? ~blink : blink;
  end

  // Blink register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      blink <= 1'b0;
    else
      blink <= blink_nxt;
  end

  assign clock_hold    = (state != RUN);
  assign load          = (state == COMMIT);
  assign mode          = state;
  assign set_hour_tens = hour_tens;
  assign set_hour_ones = hour_ones;
  assign set_min_tens  = min_tens;
  assign set_min_ones  = min_ones;

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Button-driven time-set sequencer for the DigitalClock datapath.
- Captures the running HH:MM from the clock and freezes counting while the user edits hours, then minutes, using BCD increment with wrap.
- Commits the edited value back to the clock with a single-cycle load strobe.
- Sits between debounced front-panel buttons and the DigitalClock counter chain; uses the clock's one_sec_pulse as its time base.

Parameters:
- TIMEOUT_SECS, 10: one_sec_pulse ticks without a button press before an edit is abandoned. Used only with CLK_SET_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  in  1  system clock, same domain as DigitalClock
- reset  in  1  asynchronous, active-low reset
- one_sec_pulse  in  1  single-cycle tick from DigitalClock
- btn_mode  in  1  single-cycle pulse, debounced upstream; advances the edit state
- btn_inc  in  1  single-cycle pulse, debounced upstream; increments the field being edited
- cur_hour_tens, cur_hour_ones  in  4 each  live BCD hours from the clock
- cur_min_tens, cur_min_ones  in  4 each  live BCD minutes from the clock
- clock_hold  out  1  high = DigitalClock must not advance
- load  out  1  single-cycle strobe; clock loads set_* values and clears seconds to 00
- set_hour_tens, set_hour_ones  out  4 each  edited BCD hours
- set_min_tens, set_min_ones  out  4 each  edited BCD minutes
- mode  out  2  current state encoding
- blink  out  1  display-blink enable for the field being edited

Behaviour:
- Reset (reset=0, asynchronous): state RUN, all outputs 0, edit registers 00:00, blink 0.
- States and encodings: RUN=00, SET_HOUR=01, SET_MIN=10, COMMIT=11. The mode output equals the registered state.
- RUN:
  - clock_hold=0.
  - On btn_mode, copy all cur_* inputs into the edit registers in that same edge, go to SET_HOUR and raise clock_hold the next cycle.
  - btn_inc is ignored.
- SET_HOUR:
  - btn_inc increments hours in BCD: 09->10, 19->20, 23->00.
  - Ones digit wraps 9->0 with a tens carry. Tens is never more than 2.
  - btn_mode goes to SET_MIN.
- SET_MIN:
  - btn_inc increments minutes in BCD: 09->10, 59->00.
  - No carry into hours.
  - btn_mode goes to COMMIT.
- COMMIT:
  - load=1 for exactly one cycle; set_* hold the edited values during that cycle.
  - Next cycle the state returns to RUN, with clock_hold=0 and load=0.
  - Button inputs are ignored in COMMIT.
- Latency: 1 cycle from a button pulse to the state or value update. Load is asserted 1 cycle after the btn_mode that ends SET_MIN.
- clock_hold is 1 in SET_HOUR, SET_MIN and COMMIT.
- Simultaneous btn_mode and btn_inc in the same cycle: btn_mode wins, and the increment is discarded.
- blink:
  - In SET_HOUR and SET_MIN, toggles on each one_sec_pulse.
  - Forced to 0 on entry to any state and in RUN/COMMIT.
- set_* outputs are registered and always reflect the edit registers. They are valid outside COMMIT but only meaningful when load=1.
- Edit registers hold their values after commit until the next capture.
- Invalid BCD captured from cur_* (digit greater than 9, hour tens greater than 2, or hours greater than 23) is sanitised to 0 for that field at capture.
- Reset mid-edit: immediate return to RUN with no load and clock_hold dropped asynchronously.

Optional Feature:
- Macro: CLK_SET_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter clears on entry to SET_HOUR/SET_MIN and on any btn_mode or btn_inc.
  - It increments on each one_sec_pulse while in SET_HOUR or SET_MIN.
  - When the count reaches TIMEOUT_SECS, the controller returns to RUN next cycle without asserting load (edit abandoned) and clock_hold drops.
  - A button pulse in the same cycle as the terminal tick takes priority and clears the counter.
- Undefined: no counter; SET states persist indefinitely and the TIMEOUT_SECS parameter is unused.

Test Plan:
- Reset low mid-SET_MIN with clock_hold=1 -> outputs immediately 0, mode=00, no load pulse; after release, RUN.
- cur=13:45, btn_mode, then btn_mode, then btn_mode -> mode 01,10,11; a single load cycle with set=13:45; mode=00 and clock_hold=0 the next cycle.
- cur=22:58, btn_mode; 2×btn_inc; btn_mode; 3×btn_inc; btn_mode -> load with set=00:01 (hours wrap 23->00, minutes wrap 59->00->01).
- In SET_HOUR at 09, btn_mode and btn_inc in the same cycle -> mode=10, hours remain 09.
- In SET_HOUR, 3 one_sec_pulses -> blink toggles 3 times (0->1->0->1); btn_mode -> blink=0 in SET_MIN.
- CLK_SET_TIMEOUT_EN, TIMEOUT_SECS=3: enter SET_HOUR, 1 btn_inc, then 3 one_sec_pulses -> mode=00, clock_hold=0, load never asserted; with the macro undefined, the same stimulus leaves mode=01.
